addsub_share_ctrl: RTL and testbench

//  Time-shares one combinational 8-bit add/sub unit (adder_8bit) between two requester channels.
//  - Arbitrates requests; valid/ready on each request channel.
//  - Drives operands and the mode bit into the unit and waits a settle time for the ripple chain.
//  - Returns each result on a single tagged response port with a valid/ready handshake.
//  - Sits between the datapath clients and the shared arithmetic unit.

---
 rtl/addsub_share_ctrl.sv | 113 +++++++++++
 tb/tb_addsub_share_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_share_ctrl.sv
// addsub_share_ctrl: lets two requester channels share one combinational
// 8-bit add/sub unit. Each accepted request is driven onto alu_* and held for
// SETTLE_CYCLES clocks while the ripple chain settles. The result is then
// returned on a single tagged response port.
module addsub_share_ctrl #(
  parameter int SETTLE_CYCLES = 1,   // legal 1..15
  parameter bit FAIR          = 1'b1 // 1: round-robin, 0: ch0 always wins
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_sub,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_sub,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_ch,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       busy,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_ctrl,
  input  logic [7:0] alu_p
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
  } req_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       last_gnt;  // channel granted by the last completed op
  logic       win;
  req_t       req0, req1, sel;

  assign req0 = '{a: req0_a, b: req0_b, sub: req0_sub};
  assign req1 = '{a: req1_a, b: req1_b, sub: req1_sub};

  // Arbiter: a lone requester wins; on contention it is round-robin or ch0 wins.
  always_comb begin
    win = req1_valid;
    if (req0_valid && req1_valid) win = FAIR ? ~last_gnt : 1'b0;
  end

  assign sel = win ? req1 : req0;

  // Readies are only offered in IDLE, and never while reset is held.
  assign req0_ready = rst_n && (state == IDLE) && req0_valid && !win;
  assign req1_ready = rst_n && (state == IDLE) && req1_valid &&  win;
  assign busy       = (state != IDLE);

  // Control FSM: accept -> hold operands for the settle time -> present result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      last_gnt  <= 1'b1;   // so ch0 wins the first contention
      rsp_valid <= 1'b0;
      rsp_ch    <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_ctrl  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            rsp_ch <= win;
            // The unit subtracts as b-a, so swap operands for A-B.
            alu_a    <= sel.sub ? sel.b : sel.a;
            alu_b    <= sel.sub ? sel.a : sel.b;
            alu_ctrl <= sel.sub;
            cnt      <= CNT_INIT;
            state    <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == 4'd0) begin
            rsp_data  <= alu_p;
            rsp_zero  <= (alu_p == 8'h00);
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            last_gnt  <= rsp_ch;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_share_ctrl.sv
// Bench for addsub_share_ctrl: two instances (settle 1 / round-robin and
// settle 4 / fixed priority). Each instance has a behavioural model of the
// shared unit and a transaction-level scoreboard of the controller.
module tb_addsub_share_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n [2];
  logic       v0 [2], v1 [2], s0 [2], s1 [2], rr [2];
  logic [7:0] a0 [2], b0 [2], a1 [2], b1 [2];
  logic       rdy0 [2], rdy1 [2], rv [2], rch [2], rz [2], bsy [2], ctl [2];
  logic [7:0] rd [2], aa [2], ab [2], ap [2];

  // Shared unit: p = a+b, or b-a when ctrl is set.
  assign ap[0] = ctl[0] ? ab[0] - aa[0] : aa[0] + ab[0];
  assign ap[1] = ctl[1] ? ab[1] - aa[1] : aa[1] + ab[1];

  addsub_share_ctrl #(.SETTLE_CYCLES(1), .FAIR(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]),
    .req0_valid(v0[0]), .req0_ready(rdy0[0]), .req0_a(a0[0]), .req0_b(b0[0]), .req0_sub(s0[0]),
    .req1_valid(v1[0]), .req1_ready(rdy1[0]), .req1_a(a1[0]), .req1_b(b1[0]), .req1_sub(s1[0]),
    .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_ch(rch[0]), .rsp_data(rd[0]), .rsp_zero(rz[0]),
    .busy(bsy[0]), .alu_a(aa[0]), .alu_b(ab[0]), .alu_ctrl(ctl[0]), .alu_p(ap[0]));

  addsub_share_ctrl #(.SETTLE_CYCLES(4), .FAIR(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n[1]),
    .req0_valid(v0[1]), .req0_ready(rdy0[1]), .req0_a(a0[1]), .req0_b(b0[1]), .req0_sub(s0[1]),
    .req1_valid(v1[1]), .req1_ready(rdy1[1]), .req1_a(a1[1]), .req1_b(b1[1]), .req1_sub(s1[1]),
    .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_ch(rch[1]), .rsp_data(rd[1]), .rsp_zero(rz[1]),
    .busy(bsy[1]), .alu_a(aa[1]), .alu_b(ab[1]), .alu_ctrl(ctl[1]), .alu_p(ap[1]));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int setl(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic bit fairp(input int d);
    return d == 0;
  endfunction

  // ---------------- reference model state ----------------
  int         cyc = 0;
  int         q0 [$];
  int         q1 [$];         // expected responses: {ch, data}
  int         last [2]     = '{1, 1};
  bit         pend [2]     = '{0, 0};
  int         acc_cyc [2]  = '{0, 0};
  int         prev_acc [2] = '{-1, -1};
  bit         cont [2]     = '{0, 0};
  int         r1_seen [2]  = '{0, 0};
  bit         prv_rv [2]   = '{0, 0};
  bit         prv_hold [2] = '{0, 0};
  bit         prv_ch [2], prv_rz [2];
  logic [7:0] prv_rd [2];
  logic [7:0] ea [2], eb [2];
  bit         ectl [2];

  task automatic pop(input int d, output int e);
    e = 0;
    if ((d == 0 ? q0.size() : q1.size()) == 0) begin
      chk("unexpected_rsp", 32'd1, 32'd0);
    end else if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
  endtask

  task automatic mon(input int d);
    bit         was_pend, ch, rs;
    int         e;
    logic [7:0] ra, rb, res;
    if (!rst_n[d]) begin
      last[d] = 1; pend[d] = 0; prv_rv[d] = 0; prv_hold[d] = 0;
      if (d == 0) q0.delete(); else q1.delete();
      return;
    end
    was_pend = pend[d];
    if (rdy1[d]) r1_seen[d]++;
    chk("one_ready", 32'(rdy0[d] && rdy1[d]), 32'd0);
    chk("busy", 32'(bsy[d]), 32'(was_pend));
    if (was_pend) chk("ready_when_busy", 32'(rdy0[d] || rdy1[d]), 32'd0);
    else          chk("rsp_valid_idle", 32'(rv[d]), 32'd0);
    if (prv_hold[d])
      chk("rsp_hold", 32'({rv[d], rch[d], rd[d], rz[d]}), 32'({1'b1, prv_ch[d], prv_rd[d], prv_rz[d]}));
    if (rv[d] && !prv_rv[d]) chk("latency", 32'(cyc - acc_cyc[d]), 32'(setl(d) + 1));
    if (was_pend && !rv[d])
      chk("alu_drive", 32'({aa[d], ab[d], ctl[d]}), 32'({ea[d], eb[d], ectl[d]}));
    if (was_pend && rv[d] && rr[d]) begin
      pop(d, e);
      chk("rsp", 32'({rch[d], rd[d], rz[d]}), 32'({e[8], e[7:0], e[7:0] == 8'h00}));
      last[d] = e[8];
      pend[d] = 0;
    end
    if (!was_pend && (v0[d] || v1[d])) begin
      if (v0[d] && v1[d]) ch = fairp(d) ? (last[d] == 0) : 1'b0;
      else                ch = v1[d];
      chk("grant", 32'({rdy0[d], rdy1[d]}), ch ? 32'h1 : 32'h2);
      ra  = ch ? a1[d] : a0[d];
      rb  = ch ? b1[d] : b0[d];
      rs  = ch ? s1[d] : s0[d];
      res = rs ? ra - rb : ra + rb;
      e   = {23'd0, ch, res};
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      ea[d] = rs ? rb : ra;  eb[d] = rs ? ra : rb;  ectl[d] = rs;
      if (cont[d] && prev_acc[d] >= 0) chk("accept_spacing", 32'(cyc - prev_acc[d]), 32'(setl(d) + 2));
      prev_acc[d] = cyc;
      acc_cyc[d]  = cyc;
      pend[d]     = 1;
    end
    prv_hold[d] = rv[d] && !rr[d];
    prv_rv[d]   = rv[d];
    prv_ch[d]   = rch[d];
    prv_rd[d]   = rd[d];
    prv_rz[d]   = rz[d];
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0);
    mon(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk_zero(input int d, input string tag);
    chk(tag, 32'({rdy0[d], rdy1[d], rv[d], rch[d], rz[d], bsy[d], ctl[d]}), 32'd0);
    chk(tag, 32'({rd[d], aa[d], ab[d]}), 32'd0);
  endtask

  task automatic run(input int d, input int n, input bit cm, input int rdy_pct);
    bit acc0, acc1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      acc0 = v0[d] && rdy0[d];
      acc1 = v1[d] && rdy1[d];
      @(posedge clk); #1;
      if (acc0 || !v0[d]) begin
        v0[d] = cm || ($urandom_range(1, 0) == 1);
        a0[d] = 8'($urandom); b0[d] = 8'($urandom); s0[d] = 1'($urandom);
      end else if (!cm && $urandom_range(15, 0) == 0) v0[d] = 1'b0;
      if (acc1 || !v1[d]) begin
        v1[d] = cm || ($urandom_range(1, 0) == 1);
        a1[d] = 8'($urandom); b1[d] = 8'($urandom); s1[d] = 1'($urandom);
      end else if (!cm && $urandom_range(15, 0) == 0) v1[d] = 1'b0;
      rr[d] = ($urandom_range(99, 0) < rdy_pct);
    end
  endtask

  task automatic drain(input int d);
    int k;
    @(posedge clk); #1;
    v0[d] = 1'b0; v1[d] = 1'b0; rr[d] = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (bsy[d] && k < 100);
    if (k >= 100) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic req(input int d, input bit ch, input logic [7:0] a, input logic [7:0] b, input bit s);
    int k;
    @(posedge clk); #1;
    if (ch) begin v1[d] = 1'b1; a1[d] = a; b1[d] = b; s1[d] = s; end
    else    begin v0[d] = 1'b1; a0[d] = a; b0[d] = b; s0[d] = s; end
    k = 0;
    do begin @(negedge clk); k++; end while (!(ch ? rdy1[d] : rdy0[d]) && k < 50);
    if (k >= 50) chk("req_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    if (ch) v1[d] = 1'b0; else v0[d] = 1'b0;
  endtask

  task automatic wait_rsp(input int d);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!rv[d] && k < 50);
    if (k >= 50) chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; v0[d] = 1'b0; v1[d] = 1'b0; s0[d] = 1'b0; s1[d] = 1'b0; rr[d] = 1'b0;
      a0[d] = '0; b0[d] = '0; a1[d] = '0; b1[d] = '0;
    end
    repeat (2) @(negedge clk);
    chk_zero(0, "reset_outputs");
    chk_zero(1, "reset_outputs");
    @(posedge clk); #1;
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    // ch0 5-3, operands swapped onto the unit
    rr[0] = 1'b1;
    req(0, 1'b0, 8'h05, 8'h03, 1'b1);
    @(negedge clk);
    chk("t1_alu", 32'({aa[0], ab[0], ctl[0]}), 32'({8'h03, 8'h05, 1'b1}));
    wait_rsp(0);
    chk("t1_rsp", 32'({rch[0], rd[0]}), 32'({1'b0, 8'h02}));

    // wrap-around to zero, then a borrow
    req(0, 1'b1, 8'hFF, 8'h01, 1'b0);
    wait_rsp(0);
    chk("t2_zero", 32'({rch[0], rd[0], rz[0]}), 32'({1'b1, 8'h00, 1'b1}));
    req(0, 1'b1, 8'h03, 8'h05, 1'b1);
    wait_rsp(0);
    chk("t2_borrow", 32'({rch[0], rd[0], rz[0]}), 32'({1'b1, 8'hFE, 1'b0}));
    drain(0);

    // continuous contention, round-robin
    prev_acc[0] = -1; cont[0] = 1'b1;
    run(0, 24, 1'b1, 100);
    cont[0] = 1'b0;
    drain(0);

    // consumer stalls with a competing request pending
    rr[0] = 1'b0;
    req(0, 1'b0, 8'h10, 8'h20, 1'b0);
    v1[0] = 1'b1; a1[0] = 8'h07; b1[0] = 8'h09; s1[0] = 1'b1;
    repeat (7) @(negedge clk);
    @(posedge clk); #1;
    rr[0] = 1'b1;
    drain(0);

    run(0, 400, 1'b0, 70);
    drain(0);

    // fixed priority: ch1 starves under continuous contention
    prev_acc[1] = -1; cont[1] = 1'b1; r1_seen[1] = 0;
    run(1, 40, 1'b1, 100);
    cont[1] = 1'b0;
    chk("t4_req1_ready_count", 32'(r1_seen[1]), 32'd0);
    drain(1);

    // reset during settle drops the op; next request proceeds normally
    rr[1] = 1'b1;
    req(1, 1'b0, 8'h40, 8'h02, 1'b0);
    @(negedge clk);
    #2;
    v1[1] = 1'b1; a1[1] = 8'h22; b1[1] = 8'h11; s1[1] = 1'b1;
    rst_n[1] = 1'b0;
    #1;
    chk_zero(1, "t6_async_reset");
    @(negedge clk);
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    wait_rsp(1);
    chk("t6_next_rsp", 32'({rch[1], rd[1]}), 32'({1'b1, 8'h11}));
    drain(1);

    run(1, 400, 1'b0, 70);
    drain(1);

    chk("q0_empty", 32'(q0.size()), 32'd0);
    chk("q1_empty", 32'(q1.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
